hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the five-stage RISC-V core.
- Sequences the PC, IF/ID, ID/EX and EX/MEM registers by driving their stall, flush and bubble inputs.
- Covers three cases: load-use bubbles (with configurable load latency), branch-taken flushes, and data-memory wait states with timeout.
- Sits beside the decode stage; outputs go directly to the pipeline registers' control pins.

---
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the decode-side hazard inputs and the pipeline-register control pins.
interface hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rd;
  logic       ex_memread;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_stall;
  logic       ifid_stall;
  logic       ifid_flush;
  logic       idex_stall;
  logic       idex_bubble;
  logic       idex_flush;
  logic       exmem_stall;
  logic       mem_err;
  logic [1:0] ctrl_state;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
           idex_flush, exmem_stall, mem_err, ctrl_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_branch_taken, mem_req, mem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
           idex_flush, exmem_stall, mem_err, ctrl_state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes and data-memory waits with timeout.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush/bubble cycle counters.
module hazard_ctrl #(
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]  stall_cnt,
  output logic [31:0]  flush_cnt,
  output logic [31:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0]  LU_INIT = 2'(LOAD_LAT - 1);
  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_t      state, state_nxt;
  state_t      ret_state, ret_nxt;
  logic [1:0]  lu_cnt, lu_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic        mem_err, mem_err_nxt;
  logic        haz, memwait;
  logic        pc_stall, ifid_stall, ifid_flush, idex_stall;
  logic        idex_bubble, idex_flush, exmem_stall;

  assign haz = bus.ex_memread & (bus.ex_rd != 5'd0) &
               ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));
  assign memwait = bus.mem_req & ~bus.mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      ret_state <= RUN;
      lu_cnt    <= 2'd0;
      wait_cnt  <= 16'd0;
      mem_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      lu_cnt    <= lu_nxt;
      wait_cnt  <= wait_nxt;
      mem_err   <= mem_err_nxt;
    end
  end

  // Priority in every state: memory wait, then branch flush, then load-use.
  always_comb begin
    state_nxt   = state;
    ret_nxt     = ret_state;
    lu_nxt      = lu_cnt;
    wait_nxt    = wait_cnt;
    mem_err_nxt = 1'b0;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_bubble = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    if (!reset) begin
      case (state)
        RUN, LU_STALL: begin
          if (memwait) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            state_nxt   = MEM_WAIT;
            ret_nxt     = state;
            wait_nxt    = 16'd1;
          end else if (bus.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_nxt  = RUN;
            if (state == LU_STALL) lu_nxt = 2'd0;
          end else if (state == LU_STALL) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            lu_nxt      = lu_cnt - 2'd1;
            if (lu_cnt == 2'd1) state_nxt = RUN;
          end else if (haz) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = LU_STALL;
              lu_nxt    = LU_INIT;
            end
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            state_nxt = ret_state;
          end else if (wait_cnt == TIMEOUT) begin
            // Timeout releases exactly like a late ready, flagged one cycle later.
            state_nxt   = ret_state;
            mem_err_nxt = 1'b1;
          end else begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            wait_nxt    = wait_cnt + 16'd1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign bus.pc_stall    = pc_stall;
  assign bus.ifid_stall  = ifid_stall;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_stall  = idex_stall;
  assign bus.idex_bubble = idex_bubble;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_stall = exmem_stall;
  assign bus.mem_err     = mem_err;
  assign bus.ctrl_state  = state;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= 32'd0;
      flush_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (exmem_stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
      if (idex_bubble && (bubble_cnt != 32'hFFFF_FFFF)) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: dut1 (LOAD_LAT=1, MEM_TIMEOUT=8) and dut3 (LOAD_LAT=3) share stimulus.
module tb_hazard_ctrl;
  logic       clk;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken, mem_req, mem_ready;
  int         tests_run;
  int         tests_failed;

  // Output vector order: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, idex_flush, exmem_stall
  localparam logic [6:0] NONE   = 7'b0000000;
  localparam logic [6:0] STALL4 = 7'b1101001;
  localparam logic [6:0] BUBBLE = 7'b1100100;
  localparam logic [6:0] FLUSH  = 7'b0010010;

  hazard_ctrl_if if1 ();
  hazard_ctrl_if if3 ();

  assign if1.id_rs1 = id_rs1;             assign if3.id_rs1 = id_rs1;
  assign if1.id_rs2 = id_rs2;             assign if3.id_rs2 = id_rs2;
  assign if1.id_use_rs1 = id_use_rs1;     assign if3.id_use_rs1 = id_use_rs1;
  assign if1.id_use_rs2 = id_use_rs2;     assign if3.id_use_rs2 = id_use_rs2;
  assign if1.ex_rd = ex_rd;               assign if3.ex_rd = ex_rd;
  assign if1.ex_memread = ex_memread;     assign if3.ex_memread = ex_memread;
  assign if1.ex_branch_taken = ex_branch_taken;
  assign if3.ex_branch_taken = ex_branch_taken;
  assign if1.mem_req = mem_req;           assign if3.mem_req = mem_req;
  assign if1.mem_ready = mem_ready;       assign if3.mem_ready = mem_ready;

  logic [6:0] o1, o3;
  assign o1 = {if1.pc_stall, if1.ifid_stall, if1.ifid_flush, if1.idex_stall,
               if1.idex_bubble, if1.idex_flush, if1.exmem_stall};
  assign o3 = {if3.pc_stall, if3.ifid_stall, if3.ifid_flush, if3.idex_stall,
               if3.idex_bubble, if3.idex_flush, if3.exmem_stall};

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt1, flush_cnt1, bubble_cnt1, stall_cnt3, flush_cnt3, bubble_cnt3;
`endif

  hazard_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(8)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1), .bubble_cnt(bubble_cnt1)
`endif
  );

  hazard_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(255)) dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3), .bubble_cnt(bubble_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; checks happen 1 time unit later, well before the next rising edge.
  task automatic applyStimulus(input logic memread, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic use1, input logic use2,
                               input logic branch, input logic req, input logic rdy);
    @(negedge clk);
    ex_memread = memread; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = use1; id_use_rs2 = use2; ex_branch_taken = branch;
    mem_req = req; mem_ready = rdy;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_use();
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (o1 !== NONE || o3 !== NONE) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got %b/%b expected %b", o1, o3, NONE);
    end
    tests_run++;
    if (if1.ctrl_state !== 2'd0 || if1.mem_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state got state=%0d err=%b expected 0/0", if1.ctrl_state, if1.mem_err);
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
  endtask

  task automatic test_load_use_lat1();
    do_reset();
    load_use();
    tests_run++;
    if (o1 !== BUBBLE || if1.ctrl_state !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL lu1_bubble got %b state=%0d expected %b state=0", o1, if1.ctrl_state, BUBBLE);
    end
    idle();
    tests_run++;
    if (o1 !== NONE || if1.ctrl_state !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL lu1_release got %b state=%0d expected %b state=0", o1, if1.ctrl_state, NONE);
    end
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (o1 !== NONE) begin
      tests_failed++;
      $display("[TB] FAIL lu1_rd_zero got %b expected %b", o1, NONE);
    end
    applyStimulus(1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (o1 !== BUBBLE) begin
      tests_failed++;
      $display("[TB] FAIL lu1_rs2_match got %b expected %b", o1, BUBBLE);
    end
    idle();
    applyStimulus(1'b1, 5'd9, 5'd9, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (o1 !== NONE) begin
      tests_failed++;
      $display("[TB] FAIL lu1_rs1_unused got %b expected %b", o1, NONE);
    end
    idle();
  endtask

  task automatic test_load_use_lat3();
    logic [6:0] exp_o [4];
    logic [1:0] exp_s [4];
    exp_o = '{BUBBLE, BUBBLE, BUBBLE, NONE};
    exp_s = '{2'd0, 2'd1, 2'd1, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) load_use(); else idle();
      tests_run++;
      if (o3 !== exp_o[i] || if3.ctrl_state !== exp_s[i]) begin
        tests_failed++;
        $display("[TB] FAIL lu3_cycle%0d got %b state=%0d expected %b state=%0d",
                 i, o3, if3.ctrl_state, exp_o[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_branch_hazard();
    do_reset();
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (o1 !== FLUSH || o3 !== FLUSH) begin
      tests_failed++;
      $display("[TB] FAIL branch_flush got %b/%b expected %b", o1, o3, FLUSH);
    end
    idle();
    tests_run++;
    if (o1 !== NONE || o3 !== NONE || if3.ctrl_state !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL branch_after got %b/%b state=%0d expected %b state=0", o1, o3, if3.ctrl_state, NONE);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tests_run++;
      if (o1 !== STALL4 || if1.ctrl_state !== ((i == 0) ? 2'd0 : 2'd2) || if1.mem_err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL memwait_cycle%0d got %b state=%0d err=%b expected %b err=0",
                 i, o1, if1.ctrl_state, if1.mem_err, STALL4);
      end
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tests_run++;
    if (o1 !== NONE || if1.ctrl_state !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL memwait_ready got %b state=%0d expected %b state=2", o1, if1.ctrl_state, NONE);
    end
    idle();
    tests_run++;
    if (if1.ctrl_state !== 2'd0 || if1.mem_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL memwait_return got state=%0d err=%b expected 0/0", if1.ctrl_state, if1.mem_err);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tests_run++;
      if (o1 !== ((i < 8) ? STALL4 : NONE) || if1.mem_err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL timeout_cycle%0d got %b err=%b expected %b err=0",
                 i, o1, if1.mem_err, (i < 8) ? STALL4 : NONE);
      end
    end
    idle();
    tests_run++;
    if (if1.mem_err !== 1'b1 || if1.ctrl_state !== 2'd0 || o1 !== NONE) begin
      tests_failed++;
      $display("[TB] FAIL timeout_err got err=%b state=%0d out=%b expected 1/0/%b",
               if1.mem_err, if1.ctrl_state, o1, NONE);
    end
    idle();
    tests_run++;
    if (if1.mem_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_err_pulse got %b expected 0", if1.mem_err);
    end
  endtask

  task automatic test_lu_mem_wait();
    do_reset();
    load_use();
    tests_run++;
    if (o3 !== BUBBLE) begin
      tests_failed++;
      $display("[TB] FAIL lumem_enter got %b expected %b", o3, BUBBLE);
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (o3 !== STALL4 || if3.ctrl_state !== 2'd1) begin
      tests_failed++;
      $display("[TB] FAIL lumem_wait got %b state=%0d expected %b state=1", o3, if3.ctrl_state, STALL4);
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tests_run++;
    if (o3 !== NONE || if3.ctrl_state !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL lumem_ready got %b state=%0d expected %b state=2", o3, if3.ctrl_state, NONE);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      tests_run++;
      if (o3 !== ((i < 2) ? BUBBLE : NONE) || if3.ctrl_state !== ((i < 2) ? 2'd1 : 2'd0)) begin
        tests_failed++;
        $display("[TB] FAIL lumem_resume%0d got %b state=%0d expected %b state=%0d",
                 i, o3, if3.ctrl_state, (i < 2) ? BUBBLE : NONE, (i < 2) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (o1 !== STALL4 || if1.ctrl_state !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL midreset_pre got %b state=%0d expected %b state=2", o1, if1.ctrl_state, STALL4);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    tests_run++;
    if (o1 !== NONE || o3 !== NONE || if1.ctrl_state !== 2'd0 || if3.ctrl_state !== 2'd0 ||
        if1.mem_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset got %b/%b state=%0d/%0d err=%b expected all 0",
               o1, o3, if1.ctrl_state, if3.ctrl_state, if1.mem_err);
    end
`ifdef HAZARD_PERF_CNT_EN
    tests_run++;
    if ((stall_cnt1 | flush_cnt1 | bubble_cnt1 | stall_cnt3 | flush_cnt3 | bubble_cnt3) !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_counters got %0d/%0d/%0d expected 0",
               stall_cnt1, flush_cnt1, bubble_cnt1);
    end
`endif
    @(negedge clk);
    idle();
    reset = 1'b0;
    idle();
    tests_run++;
    if (o1 !== NONE || if1.ctrl_state !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_after got %b state=%0d expected %b state=0", o1, if1.ctrl_state, NONE);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    ex_memread = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_load_use_lat1();
    test_load_use_lat3();
    test_branch_hazard();
    test_mem_wait();
    test_timeout();
    test_lu_mem_wait();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
